// File: rtl/cbm2_pkg.sv
// Shared types and constants for the CBM-II RAM controller.
package cbm2_pkg;

    // System / memory address width.
    localparam int AW = 25;

    // Indices into the request-slot bank inside the controller.
    localparam int SLOT_PEND = 0;  // bus access waiting for / occupying the memory port
    localparam int SLOT_SEC  = 1;  // bus access that arrived after the pending one was issued
    localparam int SLOT_LOAD = 2;  // loader download byte
    localparam int N_SLOTS   = 3;

    // Memory port sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_LOAD = 2'd2
    } ramctl_state_t;

    // One memory access: address, direction, write data.
    typedef struct packed {
        logic [AW-1:0] addr;
        logic          we;
        logic [7:0]    data;
    } ramctl_req_t;

    function automatic ramctl_req_t mk_req(input logic [AW-1:0] addr,
                                           input logic          we,
                                           input logic [7:0]    data);
        ramctl_req_t req;
        req.addr = addr;
        req.we   = we;
        req.data = data;
        return req;
    endfunction

endpackage

// File: rtl/cbm2_ramctl_slot.sv
// Single-entry request register with a valid flag.
// A load wins over a clear issued in the same clock, so a slot can be
// refilled in the cycle it is retired.
module cbm2_ramctl_slot
    import cbm2_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_clear,
    input  ramctl_req_t i_d,
    output ramctl_req_t o_q,
    output logic        o_valid
);

    ramctl_req_t r_q;
    logic        r_valid;

    // Capture a request or retire the current one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q     <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_q     <= i_d;
            r_valid <= 1'b1;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    assign o_q     = r_q;
    assign o_valid = r_valid;

endmodule

// File: rtl/cbm2_ramctl.sv
// CBM-II memory-side responder: serves bus slots on a req/ack memory port
// and drains a one-entry loader buffer in otherwise idle slots.
module cbm2_ramctl #(
    parameter int AW                = cbm2_pkg::AW,
    parameter int LOAD_PRIO_TIMEOUT = 0
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          cycle_start,
    input  logic [AW-1:0] systemAddr,
    input  logic          systemWe,
    input  logic          cs_ram,
    input  logic [7:0]    cpuDo,
    output logic [7:0]    ramData,
    output logic          bus_busy,
    output logic          overrun,
    input  logic          ioctl_wr,
    input  logic [AW-1:0] ioctl_addr,
    input  logic [7:0]    ioctl_data,
    output logic          ioctl_wait,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [7:0]    mem_din,
    input  logic [7:0]    mem_dout,
    input  logic          mem_ack
);

    import cbm2_pkg::*;

    // The request record is sized by the package width, and the bus always
    // has priority over the loader; reject any other configuration.
    generate
        if (AW != cbm2_pkg::AW || LOAD_PRIO_TIMEOUT != 0) begin : g_param_check
            $error("cbm2_ramctl: AW must equal cbm2_pkg::AW and LOAD_PRIO_TIMEOUT must be 0");
        end
    endgenerate

    logic [1:0]          r_rst_sync;
    logic                w_rst_n;
    ramctl_state_t       r_state;
    logic                r_mem_req;
    logic [AW-1:0]       r_mem_addr;
    logic                r_mem_we;
    logic [7:0]          r_mem_din;
    logic [7:0]          r_ram_data;
    logic                r_overrun;

    logic [N_SLOTS-1:0]  w_slot_load;
    logic [N_SLOTS-1:0]  w_slot_clear;
    logic [N_SLOTS-1:0]  w_slot_valid;
    ramctl_req_t         w_slot_d [N_SLOTS];
    ramctl_req_t         w_slot_q [N_SLOTS];

    logic                w_bus_slot;
    logic                w_bus_ack;
    logic                w_load_ack;
    logic                w_pend_issued;
    ramctl_req_t         w_new_req;
    ramctl_req_t         w_issue_req;

    // Reset asserts asynchronously and releases two clocks after reset_n rises.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    assign w_bus_slot    = cycle_start & cs_ram;
    assign w_bus_ack     = (r_state == ST_BUS) & mem_ack;
    assign w_load_ack    = (r_state == ST_LOAD) & mem_ack;
    assign w_pend_issued = (r_state == ST_BUS);
    assign w_new_req     = mk_req(systemAddr, systemWe, cpuDo);
    // A slot arriving in IDLE goes straight to the port; otherwise use the pending entry.
    assign w_issue_req   = w_bus_slot ? w_new_req : w_slot_q[SLOT_PEND];

    // Slot bank: pending bus access, overflow bus access, loader byte.
    generate
        for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_slot
            cbm2_ramctl_slot u_slot (
                .clk     (clk_sys),
                .rst_n   (w_rst_n),
                .i_load  (w_slot_load[gi]),
                .i_clear (w_slot_clear[gi]),
                .i_d     (w_slot_d[gi]),
                .o_q     (w_slot_q[gi]),
                .o_valid (w_slot_valid[gi])
            );
        end
    endgenerate

    // Route new slots: overwrite the pending entry unless it is already on
    // the port, in which case park it as the second entry; promote on ack.
    always_comb begin
        w_slot_load           = '0;
        w_slot_clear          = '0;
        w_slot_d[SLOT_PEND]   = w_new_req;
        w_slot_d[SLOT_SEC]    = w_new_req;
        w_slot_d[SLOT_LOAD]   = mk_req(ioctl_addr, 1'b1, ioctl_data);

        if (w_bus_ack) begin
            w_slot_clear[SLOT_PEND] = 1'b1;
            if (w_slot_valid[SLOT_SEC]) begin
                w_slot_load[SLOT_PEND]  = 1'b1;
                w_slot_d[SLOT_PEND]     = w_slot_q[SLOT_SEC];
                w_slot_clear[SLOT_SEC]  = 1'b1;
                w_slot_load[SLOT_SEC]   = w_bus_slot;
            end else begin
                w_slot_load[SLOT_PEND]  = w_bus_slot;
            end
        end else if (w_bus_slot) begin
            if (w_slot_valid[SLOT_PEND] && w_pend_issued) begin
                w_slot_load[SLOT_SEC]  = 1'b1;
            end else begin
                w_slot_load[SLOT_PEND] = 1'b1;
            end
        end

        // A write while the buffer is full is a loader protocol violation and is dropped.
        w_slot_load[SLOT_LOAD]  = ioctl_wr & ~w_slot_valid[SLOT_LOAD];
        w_slot_clear[SLOT_LOAD] = w_load_ack;
    end

    // Sticky flag: a RAM slot started while the previous bus access was unfinished.
    always_ff @(posedge clk_sys or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_bus_slot && w_slot_valid[SLOT_PEND]) begin
            r_overrun <= 1'b1;
        end
    end

    // Memory port sequencer with registered port outputs and read-data latch.
    always_ff @(posedge clk_sys or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state    <= ST_IDLE;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_mem_we   <= 1'b0;
            r_mem_din  <= 8'h00;
            r_ram_data <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_bus_slot || w_slot_valid[SLOT_PEND]) begin
                        r_state    <= ST_BUS;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= w_issue_req.addr;
                        r_mem_we   <= w_issue_req.we;
                        r_mem_din  <= w_issue_req.data;
                    end else if (w_slot_valid[SLOT_LOAD]) begin
                        r_state    <= ST_LOAD;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= w_slot_q[SLOT_LOAD].addr;
                        r_mem_we   <= 1'b1;
                        r_mem_din  <= w_slot_q[SLOT_LOAD].data;
                    end
                end
                ST_BUS: begin
                    if (mem_ack) begin
                        r_state   <= ST_IDLE;
                        r_mem_req <= 1'b0;
                        if (!r_mem_we) begin
                            r_ram_data <= mem_dout;
                        end
                    end
                end
                ST_LOAD: begin
                    if (mem_ack) begin
                        r_state   <= ST_IDLE;
                        r_mem_req <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign ramData    = r_ram_data;
    assign bus_busy   = w_slot_valid[SLOT_PEND];
    assign overrun    = r_overrun;
    assign ioctl_wait = w_slot_valid[SLOT_LOAD];
    assign mem_req    = r_mem_req;
    assign mem_addr   = r_mem_addr;
    assign mem_we     = r_mem_we;
    assign mem_din    = r_mem_din;

endmodule
